mem_bus_ctrl: RTL and testbench

Bus controller between the pipeline MEM stage and the 128x32 word RAM, which uses a shared tri-state data bus and a write-enable line.
- Accepts single-word read/write requests with byte addresses.
- Checks alignment and range, and converts byte addresses to word addresses.
- Sequences the RAM's address, write-enable and bidirectional data bus through a multi-cycle access.
- Returns registered read data with a one-cycle ack pulse.

---
 rtl/mem_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Bus controller between the MEM stage and a 128x32 word RAM with a shared
// tri-state data bus: checks the byte address, then runs SETUP/ACCESS/DONE.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       byte_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wre,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF < 2) ? 1 : $clog2(WAIT_EFF + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_wre_q, ram_wre_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                legal;

  // Word aligned and inside the RAM's byte window.
  assign legal = (byte_addr[1:0] == 2'b00) &&
                 ((byte_addr >> (ADDR_W + 2)) == 32'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          wdata_d = wdata;
          if (legal) begin
            state_d    = SETUP;
            ram_addr_d = byte_addr[ADDR_W+1:2];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(WAIT_EFF);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          if (!we_q) rdata_d = ram_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered with it.
    ack_d     = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    ram_wre_d = (state_d == ACCESS) && we_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_wre_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_wre_q  <= ram_wre_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    wdata_q <= wdata_d;
  end

  // Bus driver shares the ram_wre flop, so drive and write enable never skew.
  assign ram_data = ram_wre_q ? wdata_q : {DATA_W{1'bz}};

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign ram_addr = ram_addr_q;
  assign ram_wre  = ram_wre_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3, each attached to a small behavioural RAM on its bus.
module tb_mem_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ack1, err1, busy1, ram_wre1;
  logic [6:0]  ram_addr1;
  wire  [31:0] ram_data1;

  logic        req3 = 1'b0, we3 = 1'b0;
  logic [31:0] addr3 = '0, wdata3 = '0;
  logic [31:0] rdata3;
  logic        ack3, err3, busy3, ram_wre3;
  logic [6:0]  ram_addr3;
  wire  [31:0] ram_data3;

  logic [31:0] mem1 [128];
  logic [31:0] mem3 [128];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_ctrl #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .we(we1), .byte_addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1),
    .ram_addr(ram_addr1), .ram_wre(ram_wre1), .ram_data(ram_data1)
  );

  mem_bus_ctrl #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .req(req3), .we(we3), .byte_addr(addr3),
    .wdata(wdata3), .rdata(rdata3), .ack(ack3), .err(err3), .busy(busy3),
    .ram_addr(ram_addr3), .ram_wre(ram_wre3), .ram_data(ram_data3)
  );

  // Behavioural RAMs: drive the bus whenever not being written.
  assign ram_data1 = ram_wre1 ? 32'bz : mem1[ram_addr1];
  assign ram_data3 = ram_wre3 ? 32'bz : mem3[ram_addr3];

  always @(posedge clock) begin
    if (ram_wre1) mem1[ram_addr1] <= ram_data1;
    if (ram_wre3) mem3[ram_addr3] <= ram_data3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on dut1; checks latency, write strobe, bus data and address.
  task automatic access1(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_idx, input string tag);
    int          lat;
    int          wre_cnt;
    logic [31:0] bus;
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    @(negedge clock);
    req1 = 1'b0;
    lat = 1; wre_cnt = 0; bus = '0;
    while (!ack1 && lat < 10) begin
      if (ram_wre1) begin
        wre_cnt++;
        bus = ram_data1;
      end
      @(negedge clock);
      lat++;
    end
    check({tag, " ack latency"}, lat, 3);
    check({tag, " wre cycles"}, wre_cnt, w ? 1 : 0);
    if (w) check({tag, " bus data"}, bus, d);
    check({tag, " ram_addr"}, 32'(ram_addr1), exp_idx);
    check({tag, " err with ack"}, 32'(err1), 0);
    check({tag, " wre in DONE"}, 32'(ram_wre1), 0);
    @(negedge clock);
    check({tag, " ack pulse"}, 32'(ack1), 0);
    check({tag, " busy idle"}, 32'(busy1), 0);
  endtask

  task automatic reject1(input logic [31:0] a, input string tag);
    req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = 32'hBAD0BAD0;
    @(negedge clock);
    check({tag, " err"}, 32'(err1), 1);
    check({tag, " busy"}, 32'(busy1), 0);
    check({tag, " wre"}, 32'(ram_wre1), 0);
    check({tag, " ack"}, 32'(ack1), 0);
    req1 = 1'b0;
    @(negedge clock);
    check({tag, " err pulse"}, 32'(err1), 0);
    check({tag, " busy after"}, 32'(busy1), 0);
    check({tag, " wre after"}, 32'(ram_wre1), 0);
  endtask

  initial begin
    int acks;
    int prev_ack;
    int lowrun;
    int wre_seen;
    logic [31:0] exp_rd;

    for (int i = 0; i < 128; i++) begin
      mem1[i] = '0;
      mem3[i] = 32'hA000_0000 | i;
    end
    mem1[0] = 32'h0F0F_0F0F;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst rdata", rdata1, 0);
    check("rst ack", 32'(ack1), 0);
    check("rst err", 32'(err1), 0);
    check("rst busy", 32'(busy1), 0);
    check("rst wre", 32'(ram_wre1), 0);
    check("rst ram_addr", 32'(ram_addr1), 0);
    check("rst bus", ram_data1, 32'h0F0F_0F0F);
    reset = 1'b1;
    @(negedge clock);

    // Write then read back with WAIT_CYCLES=1
    access1(1'b1, 32'h0C, 32'h1414_1414, 3, "wr 0x0C");
    check("mem[3] written", mem1[3], 32'h1414_1414);
    access1(1'b0, 32'h0C, 32'h0, 3, "rd 0x0C");
    check("rd 0x0C rdata", rdata1, 32'h1414_1414);
    access1(1'b1, 32'h10, 32'h5555_5555, 4, "wr 0x10");
    check("rdata after write", rdata1, 32'h1414_1414);

    // Rejected requests
    reject1(32'h0E, "rej 0x0E");
    reject1(32'h200, "rej 0x200");
    check("rdata after reject", rdata1, 32'h1414_1414);
    check("ram_addr after reject", 32'(ram_addr1), 4);

    // Top of the address window
    access1(1'b1, 32'h1FC, 32'hDEAD_BEEF, 127, "wr 0x1FC");
    access1(1'b0, 32'h1FC, 32'h0, 127, "rd 0x1FC");
    check("rd 0x1FC rdata", rdata1, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a write
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h5A5A_5A5A;
    @(negedge clock);
    req1 = 1'b0;
    @(negedge clock);
    check("abort wre before", 32'(ram_wre1), 1);
    check("abort bus before", ram_data1, 32'h5A5A_5A5A);
    #2 reset = 1'b0;
    #1;
    check("abort wre", 32'(ram_wre1), 0);
    check("abort bus released", ram_data1, 32'h0F0F_0F0F);
    check("abort busy", 32'(busy1), 0);
    check("abort ack", 32'(ack1), 0);
    check("abort rdata", rdata1, 0);
    check("abort ram_addr", 32'(ram_addr1), 0);
    @(negedge clock);
    reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ack1) acks++;
    end
    check("abort no ack", acks, 0);
    check("abort mem untouched", mem1[16], 0);

    // WAIT_CYCLES=3, req held high for back-to-back reads
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h20;
    acks = 0; prev_ack = -1; lowrun = 0; wre_seen = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (ram_wre3) wre_seen++;
      if (!busy3) lowrun++;
      else if (lowrun != 0) begin
        check("w3 busy low run", lowrun, 1);
        lowrun = 0;
      end
      if (ack3) begin
        acks++;
        if (prev_ack >= 0) check("w3 ack period", cyc - prev_ack, 6);
        prev_ack = cyc;
        exp_rd = 32'hA000_0000 | 32'(addr3[8:2]);
        check("w3 rdata", rdata3, exp_rd);
        addr3 = addr3 + 32'd4;
      end
    end
    req3 = 1'b0;
    check("w3 ack count", acks, 5);
    check("w3 wre never", wre_seen, 0);
    check("w3 err", 32'(err3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
